// File: rtl/alu_operand_loader.sv
// Operand loader for the ALU: three debounced buttons capture A, B and the opcode from
// the switch bus, and a valid/ready handshake presents the full operand set downstream.
module alu_operand_loader #(
  parameter int NB_SW           = 8,
  parameter int NB_DATA         = 8,
  parameter int NB_OPCODE       = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_CLEAR      = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_SW-1:0]     i_sw,
  input  logic                 i_btn_a,
  input  logic                 i_btn_b,
  input  logic                 i_btn_op,
  input  logic                 i_ready,
  output logic [NB_DATA-1:0]   o_a,
  output logic [NB_DATA-1:0]   o_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [2:0]           o_loaded,
  output logic                 o_valid,
  output logic                 o_accept
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] btn;
  logic [2:0] rise;
  logic       transfer;
  logic       clear_flags;
  logic       unused_sw;

  assign btn = {i_btn_op, i_btn_b, i_btn_a};

  // Switch bits above the operand/opcode widths are intentionally dropped.
  assign unused_sw = ^i_sw;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic             sync_p0;
    logic             sync_p1;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // p0/p1: two-flop synchroniser; then the debounce counter and edge history
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        deb     <= 1'b0;
        deb_d   <= 1'b0;
        cnt     <= '0;
      end else begin
        sync_p0 <= btn[g];
        sync_p1 <= sync_p0;
        deb_d   <= deb;
        if (sync_p1 == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb <= sync_p1;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign rise[g] = deb & ~deb_d;
  end

  assign o_valid     = &o_loaded;
  assign transfer    = o_valid & i_ready;
  assign clear_flags = transfer && (AUTO_CLEAR != 0);

  // Capture stage: a rise on a channel beats a same-cycle clear of its flag
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_a      <= '0;
      o_b      <= '0;
      o_opcode <= '0;
      o_loaded <= 3'b000;
      o_accept <= 1'b0;
    end else begin
      if (rise[0]) o_a      <= i_sw[NB_DATA-1:0];
      if (rise[1]) o_b      <= i_sw[NB_DATA-1:0];
      if (rise[2]) o_opcode <= i_sw[NB_OPCODE-1:0];
      for (int i = 0; i < 3; i++) begin
        if (rise[i]) begin
          o_loaded[i] <= 1'b1;
        end else if (clear_flags) begin
          o_loaded[i] <= 1'b0;
        end
      end
      o_accept <= transfer;
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: one auto-clear instance and one continuous-mode
// instance share the switch and button inputs but have separate ready lines.
module tb_alu_operand_loader;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op;
  logic       ready, ready_nc;

  logic [7:0] a, b, a_nc, b_nc;
  logic [5:0] op, op_nc;
  logic [2:0] loaded, loaded_nc;
  logic       valid, valid_nc, accept, accept_nc;

  int total = 0;
  int bad   = 0;

  alu_operand_loader #(.NB_SW(8), .NB_DATA(8), .NB_OPCODE(6), .DEBOUNCE_CYCLES(4), .AUTO_CLEAR(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_sw(sw), .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
    .i_ready(ready), .o_a(a), .o_b(b), .o_opcode(op), .o_loaded(loaded), .o_valid(valid),
    .o_accept(accept)
  );

  alu_operand_loader #(.NB_SW(8), .NB_DATA(8), .NB_OPCODE(6), .DEBOUNCE_CYCLES(4), .AUTO_CLEAR(0)) dut_nc (
    .i_clock(clk), .i_reset(rst), .i_sw(sw), .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
    .i_ready(ready_nc), .o_a(a_nc), .o_b(b_nc), .o_opcode(op_nc), .o_loaded(loaded_nc),
    .o_valid(valid_nc), .o_accept(accept_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] sw;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [5:0] eop;
    logic [2:0] eld;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {btn_op, btn_b, btn_a} = 3'b000;
    ready = 1'b0;
    ready_nc = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic press(input logic [2:0] mask, input logic [7:0] val);
    sw = val;
    {btn_op, btn_b, btn_a} = mask;
    repeat (7) tick();
  endtask

  task automatic release_all();
    {btn_op, btn_b, btn_a} = 3'b000;
    repeat (10) tick();
  endtask

  initial begin
    tbl[0] = '{mask: 3'b001, sw: 8'hA5, ea: 8'hA5, eb: 8'h00, eop: 6'h00, eld: 3'b001};
    tbl[1] = '{mask: 3'b010, sw: 8'h3C, ea: 8'hA5, eb: 8'h3C, eop: 6'h00, eld: 3'b011};
    tbl[2] = '{mask: 3'b100, sw: 8'hFF, ea: 8'hA5, eb: 8'h3C, eop: 6'h3F, eld: 3'b111};
    tbl[3] = '{mask: 3'b001, sw: 8'h5A, ea: 8'h5A, eb: 8'h3C, eop: 6'h3F, eld: 3'b111};
    tbl[4] = '{mask: 3'b111, sw: 8'h81, ea: 8'h81, eb: 8'h81, eop: 6'h01, eld: 3'b111};

    sw = 8'h00;
    do_reset();

    // Idle after reset
    chk("rst_loaded", loaded, 3'b000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", {a, b, 2'b00, op}, 24'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_accept", accept, 1'b0);
    end
    chk("idle_loaded", loaded, 3'b000);
    chk("idle_data", {a, b, 2'b00, op}, 24'h0);

    // Load latency and single load while held
    sw = 8'hA5;
    btn_a = 1'b1;
    repeat (6) tick();
    chk("lat_a_early", loaded, 3'b000);
    tick();
    chk("lat_a_loaded", loaded, 3'b001);
    chk("lat_a_value", a, 8'hA5);
    sw = 8'h77;
    repeat (50) tick();
    chk("hold_single_load", a, 8'hA5);
    chk("hold_loaded", loaded, 3'b001);
    release_all();

    // Bounce on B: 3 high, 1 low, then held
    do_reset();
    sw = 8'h3C;
    btn_b = 1'b1;
    repeat (3) tick();
    btn_b = 1'b0;
    tick();
    btn_b = 1'b1;
    repeat (6) tick();
    chk("bounce_early", loaded, 3'b000);
    tick();
    chk("bounce_loaded", loaded, 3'b010);
    chk("bounce_value", b, 8'h3C);
    release_all();

    // Table of button loads, no handshake
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(tbl[i].mask, tbl[i].sw);
      chk($sformatf("tbl%0d_a", i), a, tbl[i].ea);
      chk($sformatf("tbl%0d_b", i), b, tbl[i].eb);
      chk($sformatf("tbl%0d_op", i), op, tbl[i].eop);
      chk($sformatf("tbl%0d_loaded", i), loaded, tbl[i].eld);
      chk($sformatf("tbl%0d_valid", i), valid, &tbl[i].eld);
      chk($sformatf("tbl%0d_nc_loaded", i), loaded_nc, tbl[i].eld);
      release_all();
    end

    // Handshake with a single-cycle ready
    do_reset();
    press(3'b001, 8'h05); release_all();
    press(3'b010, 8'h03); release_all();
    press(3'b100, 8'h20); release_all();
    chk("hs_valid", valid, 1'b1);
    repeat (5) tick();
    chk("hs_valid_held", valid, 1'b1);
    chk("hs_no_accept", accept, 1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("hs_accept", accept, 1'b1);
    chk("hs_cleared", loaded, 3'b000);
    chk("hs_valid_low", valid, 1'b0);
    chk("hs_data_kept", {a, b, 2'b00, op}, 24'h050320);
    tick();
    chk("hs_accept_pulse", accept, 1'b0);

    // Reload of A coincident with a transfer
    press(3'b001, 8'h11); release_all();
    press(3'b010, 8'h22); release_all();
    press(3'b100, 8'h33); release_all();
    chk("co_full", loaded, 3'b111);
    sw = 8'h77;
    btn_a = 1'b1;
    repeat (6) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("co_loaded", loaded, 3'b001);
    chk("co_a", a, 8'h77);
    chk("co_accept", accept, 1'b1);
    release_all();

    // Continuous mode: flags persist across transfers
    chk("nc_full", loaded_nc, 3'b111);
    ready_nc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nc_valid", valid_nc, 1'b1);
      chk("nc_accept", accept_nc, 1'b1);
    end
    ready_nc = 1'b0;
    tick();
    chk("nc_accept_off", accept_nc, 1'b0);
    chk("nc_loaded_kept", loaded_nc, 3'b111);

    // Reset in the middle of an opcode debounce, button held throughout
    sw = 8'h2B;
    btn_op = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mr_outputs", {a, b, 2'b00, op}, 24'h0);
    chk("mr_flags", {loaded, valid, accept}, 5'b0);
    tick();
    chk("mr_flags2", {loaded, valid, accept}, 5'b0);
    rst = 1'b0;
    repeat (6) tick();
    chk("mr_early", loaded, 3'b000);
    tick();
    chk("mr_loaded", loaded, 3'b100);
    chk("mr_op", op, 6'h2B);
    sw = 8'h15;
    repeat (20) tick();
    chk("mr_single", op, 6'h2B);
    chk("mr_loaded_kept", loaded, 3'b100);
    release_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Parametrised successor to the switch/button operand decoder feeding the ALU. Each of the three buttons (A, B, opcode) gets its own synchroniser, debouncer and rising-edge detector. Switch values are captured into width-parametrised registers, each with a per-operand valid flag. When all three fields are loaded, a valid/ready handshake presents the complete operand set to the downstream ALU/result stage.

Parameters:
NB_SW, 8, switch bus width; must be >= NB_DATA and >= NB_OPCODE
NB_DATA, 8, operand A/B width; captured from i_sw[NB_DATA-1:0]
NB_OPCODE, 6, opcode width; captured from i_sw[NB_OPCODE-1:0]
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced level changes (>= 1); counter width = clog2(DEBOUNCE_CYCLES+1)
AUTO_CLEAR, 1, 1: valid flags clear on accept; 0: flags persist after accept (continuous mode)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_sw  in  NB_SW  switch bus; must be static while a button is being processed
i_btn_a  in  1  raw button, load operand A
i_btn_b  in  1  raw button, load operand B
i_btn_op  in  1  raw button, load opcode
i_ready  in  1  downstream ready to accept the operand set
o_a  out  NB_DATA  operand A register
o_b  out  NB_DATA  operand B register
o_opcode  out  NB_OPCODE  opcode register
o_loaded  out  3  valid flags {op,b,a}, for LEDs
o_valid  out  1  complete operand set available (&o_loaded)
o_accept  out  1  registered one-cycle pulse, high the cycle after a handshake transfer

Behaviour:
- One clock (i_clock). Reset is synchronous and active-high (i_reset). All state is updated on the posedge of i_clock.
- Reset: o_a=0, o_b=0, o_opcode=0, o_loaded=0, o_valid=0, o_accept=0. Synchroniser flops, debounced levels, debounce counters and edge-history flops are all 0. Reset takes priority over every other event.
- Per button channel, all three identical and independent:
  - 2-flop synchroniser: sync1 <= btn; sync2 <= sync1.
  - Debounce: if sync2 == deb, cnt <= 0. Otherwise cnt increments; when cnt == DEBOUNCE_CYCLES-1, deb <= sync2 and cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES cycles resets cnt and never changes deb.
  - rise = deb & ~deb_d, where deb_d <= deb. rise is a one-cycle pulse. Release edges are debounced the same way but produce no load.
- Latency: the button is first sampled high at edge 1, so deb rises at edge 2+DEBOUNCE_CYCLES. The register load and valid-flag set occur at edge 3+DEBOUNCE_CYCLES, capturing i_sw at that edge.
- Holding a button produces exactly one load. A re-press needs a debounced release first.
- Load: rise_a loads o_a and sets loaded[0]. rise_b loads o_b and sets loaded[1]. rise_op loads o_opcode and sets loaded[2]. Simultaneous rises all load in the same cycle; there is no priority. A reload while a flag is already set overwrites the value and the flag stays 1.
- Handshake: transfer = o_valid & i_ready at the posedge. o_valid is combinational from the flags and does not depend on i_ready. o_a/o_b/o_opcode hold their values after a transfer; data is never cleared.
- With AUTO_CLEAR=1, each flag clears on transfer, except a flag whose channel has a rise in the same cycle: the load wins, the flag stays 1 and holds the new value.
- With AUTO_CLEAR=0, flags never clear except on reset. o_valid stays high and every cycle with i_ready high is a transfer.
- o_accept <= transfer.
- Reset while a button is held: after reset deasserts, the held level is re-synchronised and debounced from 0. Exactly one load occurs at edge 3+DEBOUNCE_CYCLES counted from the first post-reset edge.
- Upper switch bits beyond NB_DATA/NB_OPCODE are ignored; no sign extension.

Test Plan:
- Reset, then idle 20 cycles -> o_loaded=3'b000, o_valid=0, all data 0, o_accept never high.
- D=4, i_sw=8'hA5, hold i_btn_a from edge 1 -> o_a=8'hA5 and o_loaded=3'b001 at edge 7; still a single load after a 50-cycle hold.
- Bounce: i_btn_b toggled high for 3 cycles, low for 1, then held; i_sw=8'h3C -> no load from the 3-cycle pulse; o_b=8'h3C once 4 stable cycles have elapsed (edge = last rise + 6).
- Load A=8'h05, B=8'h03, op=6'h20 with i_ready=0 -> o_valid=1 held. Raise i_ready for 1 cycle -> o_accept pulses once, o_loaded=0, values 05/03/20 retained.
- AUTO_CLEAR=1: rise_a coincident with a transfer cycle -> loaded[0]=1 with the new A, loaded[2:1]=0. With AUTO_CLEAR=0, i_ready held high 5 cycles -> o_valid stays 1 and o_accept stays high 5 cycles.
- Assert i_reset mid-debounce of i_btn_op (button held) -> all outputs 0 during reset. Exactly one opcode load occurs at post-reset edge 7 (D=4).
